// File: rtl/mc_controller.sv
// Multi-cycle miniRV control unit: walks each instruction through fetch, decode, execute,
// memory and writeback, with a ready-timeout watchdog, a sticky trap and a retired-instruction count.
module mc_controller #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             inst_ready,
    input  logic             ram_ready,
    output logic             inst_req,
    output logic             ram_req,
    output logic             ram_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_op,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic [3:0]       alu_op,
    output logic             alua_sel,
    output logic             alub_sel,
    output logic [2:0]       sext_op,
    output logic             br_cmp,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);
    // state  | meaning
    // FETCH  | request instruction, wait for inst_ready
    // DECODE | classify latched opcode, trap on illegal
    // EXEC   | ALU stage; branches resolve and retire here
    // MEM    | data memory access, wait for ram_ready
    // WB     | register write and PC update
    // TRAP   | absorbing fault state until reset
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state, state_next;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [7:0] wait_cnt, wait_cnt_next, wait_inc;
    logic       trap_set;
    logic [1:0] cause_set;
    logic       ctrl_en;
    logic       unused_f7;

    logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_legal;

    assign is_r     = (opc == OPC_R);
    assign is_i     = (opc == OPC_I);
    assign is_load  = (opc == OPC_LOAD);
    assign is_store = (opc == OPC_STORE);
    assign is_br    = (opc == OPC_BRANCH);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_lui   = (opc == OPC_LUI);
    assign is_legal = is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui;

    assign wait_inc  = wait_cnt + 8'd1;
    assign unused_f7 = ^{f7[6], f7[4:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            opc        <= '0;
            f3         <= '0;
            f7         <= '0;
            wait_cnt   <= '0;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (ir_we) begin
                opc <= opcode;
                f3  <= funct3;
                f7  <= funct7;
            end
            if (pc_we)
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            if (trap_set) begin
                trap       <= 1'b1;
                trap_cause <= cause_set;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = 8'd0;
        trap_set      = 1'b0;
        cause_set     = 2'b00;
        ctrl_en       = 1'b0;
        inst_req      = 1'b0;
        ir_we         = 1'b0;
        ram_req       = 1'b0;
        ram_we        = 1'b0;
        pc_we         = 1'b0;
        npc_op        = 2'b00;
        rf_we         = 1'b0;
        br_cmp        = 1'b0;
        case (state)
            S_FETCH: begin
                inst_req = 1'b1;
                // a ready on the final allowed cycle still wins over the watchdog
                if (inst_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        state_next = S_TRAP;
                        trap_set   = 1'b1;
                        cause_set  = 2'b10;
                    end
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    trap_set   = 1'b1;
                    cause_set  = 2'b01;
                end
            end
            S_EXEC: begin
                ctrl_en = 1'b1;
                if (is_br) begin
                    br_cmp     = 1'b1;
                    pc_we      = 1'b1;
                    npc_op     = 2'b00;
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                ctrl_en = 1'b1;
                ram_req = 1'b1;
                ram_we  = is_store;
                if (ram_ready) begin
                    if (is_store) begin
                        pc_we      = 1'b1;
                        npc_op     = 2'b10;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        state_next = S_TRAP;
                        trap_set   = 1'b1;
                        cause_set  = 2'b11;
                    end
                end
            end
            S_WB: begin
                ctrl_en    = 1'b1;
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                npc_op     = is_jal ? 2'b11 : (is_jalr ? 2'b01 : 2'b10);
                state_next = S_FETCH;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        rf_wsel  = 2'b00;
        alua_sel = 1'b0;
        alub_sel = 1'b0;
        sext_op  = 3'b000;
        alu_op   = 4'b0000;
        if (ctrl_en) begin
            rf_wsel  = {opc[4], opc[2]};
            alua_sel = opc[3];
            alub_sel = !(is_r || is_br);
            sext_op  = (is_i || is_jalr || is_load) ? 3'b000 : {opc[6:5], opc[2]};
            if (is_r)
                alu_op = {f7[5], f3};
            else if (is_i)
                alu_op = {f7[5] & (f3 == 3'b101), f3};
            else if (is_br)
                alu_op = 4'b1000;
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction sequences, timeouts, illegal opcode and mid-access reset.
module tb_mc_controller;
    logic        clk, rst_n;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        inst_ready, ram_ready;
    logic        inst_req, ram_req, ram_we, ir_we, pc_we, rf_we;
    logic [1:0]  npc_op, rf_wsel, trap_cause;
    logic [3:0]  alu_op;
    logic        alua_sel, alub_sel, br_cmp, trap;
    logic [2:0]  sext_op;
    logic [31:0] instret;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] model_instret = 0;
    logic [31:0] exp_q[$];

    mc_controller #(.TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .inst_ready(inst_ready), .ram_ready(ram_ready), .inst_req(inst_req),
        .ram_req(ram_req), .ram_we(ram_we), .ir_we(ir_we), .pc_we(pc_we),
        .npc_op(npc_op), .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_op(alu_op),
        .alua_sel(alua_sel), .alub_sel(alub_sel), .sext_op(sext_op), .br_cmp(br_cmp),
        .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic expect_retire();
        model_instret = model_instret + 1;
        exp_q.push_back(model_instret);
    endtask

    task automatic expect_frozen();
        exp_q.push_back(model_instret);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // called at a negedge in FETCH; returns at the negedge in DECODE
    task automatic fetch(input logic [6:0] o, input logic [2:0] f3v, input logic [6:0] f7v);
        opcode = o;
        funct3 = f3v;
        funct7 = f7v;
        inst_ready = 1'b1;
        #1;
        chk("fetch_ir_we", {31'd0, ir_we}, 32'd1);
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inst_ready = 1'b0;
        ram_ready = 1'b0;
        model_instret = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        inst_ready = 1'b0;
        ram_ready = 1'b0;
        #12;
        chk("rst_inst_req", {31'd0, inst_req}, 32'd1);
        chk("rst_ir_we", {31'd0, ir_we}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_trap", {30'd0, trap_cause, trap}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        fetch(7'b0110011, 3'b000, 7'b0000000);
        expect_retire();
        tick();
        chk("add_exec_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        chk("add_wb_rf_we", {31'd0, rf_we}, 32'd1);
        chk("add_wb_rf_wsel", {30'd0, rf_wsel}, 32'd2);
        chk("add_wb_alu_op", {28'd0, alu_op}, 32'd0);
        chk("add_wb_alub", {31'd0, alub_sel}, 32'd0);
        chk("add_wb_pc", {29'd0, pc_we, npc_op}, 32'b110);
        tick();
        chk("add_back_fetch", {31'd0, inst_req}, 32'd1);
        sb_chk("add_instret", instret);

        // LW, ram_ready after 3 wait cycles
        fetch(7'b0000011, 3'b010, 7'b0);
        expect_retire();
        ticks(2);
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", {30'd0, ram_req, ram_we}, 32'b10);
            tick();
        end
        ram_ready = 1'b1;
        #1;
        chk("lw_mem_ready", {30'd0, ram_req, ram_we}, 32'b10);
        tick();
        ram_ready = 1'b0;
        chk("lw_wb_rf_wsel", {30'd0, rf_wsel}, 32'd0);
        chk("lw_wb_sext", {29'd0, sext_op}, 32'd0);
        chk("lw_wb_rf_we", {31'd0, rf_we}, 32'd1);
        tick();
        chk("lw_back_fetch", {31'd0, inst_req}, 32'd1);
        sb_chk("lw_instret", instret);

        // SW
        fetch(7'b0100011, 3'b010, 7'b0);
        expect_retire();
        ticks(2);
        ram_ready = 1'b1;
        #1;
        chk("sw_mem_req_we", {30'd0, ram_req, ram_we}, 32'b11);
        chk("sw_mem_rf_we", {31'd0, rf_we}, 32'd0);
        chk("sw_mem_pc", {29'd0, pc_we, npc_op}, 32'b110);
        tick();
        ram_ready = 1'b0;
        chk("sw_back_fetch", {31'd0, inst_req}, 32'd1);
        sb_chk("sw_instret", instret);

        // BEQ
        fetch(7'b1100011, 3'b000, 7'b0);
        expect_retire();
        tick();
        chk("beq_br_cmp", {31'd0, br_cmp}, 32'd1);
        chk("beq_pc", {29'd0, pc_we, npc_op}, 32'b100);
        chk("beq_alu_op", {28'd0, alu_op}, 32'h8);
        chk("beq_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        sb_chk("beq_instret", instret);

        // SRAI
        fetch(7'b0010011, 3'b101, 7'b0100000);
        expect_retire();
        tick();
        chk("srai_alu_op", {28'd0, alu_op}, 32'hD);
        chk("srai_alub", {31'd0, alub_sel}, 32'd1);
        ticks(2);
        sb_chk("srai_instret", instret);

        // JAL
        fetch(7'b1101111, 3'b000, 7'b0);
        expect_retire();
        tick();
        chk("jal_alua", {31'd0, alua_sel}, 32'd1);
        tick();
        chk("jal_npc_op", {30'd0, npc_op}, 32'd3);
        chk("jal_rf_wsel", {30'd0, rf_wsel}, 32'd1);
        tick();
        sb_chk("jal_instret", instret);

        // JALR
        fetch(7'b1100111, 3'b000, 7'b0);
        expect_retire();
        ticks(2);
        chk("jalr_npc_op", {30'd0, npc_op}, 32'd1);
        chk("jalr_sext", {29'd0, sext_op}, 32'd0);
        tick();
        sb_chk("jalr_instret", instret);

        // LUI
        fetch(7'b0110111, 3'b000, 7'b0);
        expect_retire();
        ticks(2);
        chk("lui_rf_wsel", {30'd0, rf_wsel}, 32'd3);
        chk("lui_sext", {29'd0, sext_op}, 32'd3);
        tick();
        sb_chk("lui_instret", instret);

        // inst_ready on the 15th FETCH cycle still succeeds
        ticks(14);
        fetch(7'b0110011, 3'b000, 7'b0);
        expect_retire();
        chk("fetch_edge_no_trap", {31'd0, trap}, 32'd0);
        ticks(3);
        sb_chk("fetch_edge_instret", instret);

        // fetch timeout
        ticks(14);
        chk("fto_pre_trap", {30'd0, inst_req, trap}, 32'b10);
        tick();
        chk("fto_trap", {29'd0, trap_cause, trap}, 32'b101);
        chk("fto_inst_req", {31'd0, inst_req}, 32'd0);
        inst_ready = 1'b1;
        expect_frozen();
        ticks(3);
        chk("fto_sticky", {29'd0, trap_cause, trap}, 32'b101);
        chk("fto_ir_we", {31'd0, ir_we}, 32'd0);
        sb_chk("fto_instret", instret);

        // ram timeout on LW
        do_reset();
        fetch(7'b0000011, 3'b010, 7'b0);
        ticks(2);
        ticks(14);
        chk("rto_pre_trap", {30'd0, ram_req, trap}, 32'b10);
        tick();
        chk("rto_trap", {29'd0, trap_cause, trap}, 32'b111);
        chk("rto_ram_req", {31'd0, ram_req}, 32'd0);
        expect_frozen();
        ticks(3);
        chk("rto_sticky", {29'd0, trap_cause, trap}, 32'b111);
        sb_chk("rto_instret", instret);

        // illegal opcode
        do_reset();
        fetch(7'b1111111, 3'b000, 7'b0);
        chk("ill_decode_no_trap", {31'd0, trap}, 32'd0);
        tick();
        chk("ill_trap", {29'd0, trap_cause, trap}, 32'b011);
        ticks(4);
        chk("ill_sticky", {29'd0, trap_cause, trap}, 32'b011);

        // reset asserted during store MEM
        do_reset();
        fetch(7'b0100011, 3'b010, 7'b0);
        ticks(2);
        chk("rst_mem_pre", {30'd0, ram_req, ram_we}, 32'b11);
        #2;
        rst_n = 1'b0;
        model_instret = 0;
        #1;
        chk("rst_mem_drop", {30'd0, ram_req, ram_we}, 32'b00);
        chk("rst_mem_pc_we", {31'd0, pc_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_frozen();
        tick();
        chk("rst_mem_fetch", {31'd0, inst_req}, 32'd1);
        sb_chk("rst_mem_instret", instret);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle miniRV decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready-handshakes to instruction and data memory.
- Latches opcode/funct3/funct7 and drives the existing datapath control encodings per state, plus PC/IR write enables, a timeout watchdog, a sticky trap and a retired-instruction counter.

Parameters:
- TIMEOUT, 15, max wait cycles for inst_ready/ram_ready before trapping (1..255).
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction opcode, valid with inst_ready
- funct3  in  3  instruction funct3, valid with inst_ready
- funct7  in  7  instruction funct7, valid with inst_ready
- inst_ready  in  1  instruction memory data valid
- ram_ready  in  1  data memory access complete
- inst_req  out  1  fetch request
- ram_req  out  1  data memory request
- ram_we  out  1  data memory write (qualifies ram_req)
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC this cycle
- npc_op  out  2  00 branch, 01 jalr, 10 pc+4, 11 jal
- rf_we  out  1  register file write
- rf_wsel  out  2  00 ram, 01 pc+4, 10 alu, 11 imm
- alu_op  out  4  {bit3, funct3}
- alua_sel  out  1  1 = PC operand
- alub_sel  out  1  1 = immediate operand
- sext_op  out  3  immediate format select
- br_cmp  out  1  branch compare active (datapath resolves taken)
- trap  out  1  sticky fault
- trap_cause  out  2  01 illegal, 10 fetch timeout, 11 ram timeout
- instret  out  CNT_W  retired instruction count

Behaviour:
- Async reset: state=FETCH; IR fields=0; wait counter=0; instret=0; trap=0; trap_cause=00. All enables are 0 except inst_req, which is 1 immediately after reset.
- All datapath controls are Moore outputs decoded from state and the latched opc/f3/f7. Every enable is 0 outside the states listed below.
- Supported opcodes:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
  - Any other opcode in DECODE -> TRAP, cause 01.
- FETCH:
  - inst_req=1.
  - On inst_ready: ir_we=1, fields latched, go to DECODE, wait counter cleared.
  - Otherwise the counter increments; reaching TIMEOUT -> TRAP, cause 10.
- DECODE: one cycle, classify; -> EXEC.
- EXEC by class:
  - R/I/LUI -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: br_cmp=1, pc_we=1, npc_op=00, retire, -> FETCH.
  - JAL/JALR -> WB.
- MEM:
  - ram_req=1; ram_we=1 for STORE only.
  - On ram_ready: LOAD -> WB; STORE -> pc_we=1, npc_op=10, retire, -> FETCH.
  - Counter reaching TIMEOUT -> TRAP, cause 11.
- WB:
  - rf_we=1.
  - pc_we=1; npc_op per class (R/I/LUI/LOAD 10, JAL 11, JALR 01).
  - Retire, -> FETCH.
- Decoded controls, held constant from EXEC through WB:
  - rf_wsel={opc[4],opc[2]}.
  - alua_sel=opc[3].
  - alub_sel=1 except R and BRANCH.
  - sext_op=000 for I/JALR/LOAD, else {opc[6:5],opc[2]}.
- alu_op rules:
  - R: {f7[5], f3}.
  - I: {f7[5]&(f3==101), f3}.
  - BRANCH: 1000 (SUB).
  - All others: 0000 (ADD).
- Retire: instret increments by 1 on the cycle pc_we=1 and wraps modulo 2^CNT_W.
- inst_ready and ram_ready are ignored outside FETCH and MEM respectively.
- Ready arriving on the same cycle the counter hits TIMEOUT counts as success; ready wins.
- TRAP: absorbing state. All enables and requests are 0; trap=1 and trap_cause are held until rst_n. instret is frozen.
- Reset asserted mid-instruction aborts immediately. No partial writes are issued after rst_n falls.

Test Plan:
- ADD x3,x1,x2 (opc 0110011, f3 000, f7 0000000), inst_ready in 1st FETCH cycle -> 4 cycles F,D,E,WB. In WB: rf_we=1, rf_wsel=10, alu_op=0000, alub_sel=0. instret 0->1.
- LW with ram_ready after 3 waits -> MEM lasts 4 cycles with ram_req=1, ram_we=0. WB rf_wsel=00, sext_op=000. Total 8 cycles.
- SW then BEQ (f3 000) -> SW: MEM ram_we=1, no rf_we. BEQ: EXEC br_cmp=1, pc_we=1, npc_op=00, alu_op=1000. instret +2.
- SRAI (opc 0010011, f3 101, f7 0100000) -> alu_op=1101, alub_sel=1. JAL -> WB npc_op=11, rf_wsel=01, alua_sel=1.
- inst_ready held 0 with TIMEOUT=15 -> trap=1, cause=10 after 15 FETCH cycles. ram_ready held 0 on LW -> cause=11. Opcode 1111111 -> cause=01 after DECODE. All three stick until reset.
- rst_n pulsed low during MEM of a store -> ram_req/ram_we drop asynchronously. After release: FETCH, instret=0.
